counter_ctrl: RTL and testbench
===============================

Name: counter_ctrl

Overview:
Sequencer for the T-flip-flop ripple-enable counter. It takes start/stop commands, paces counting with a programmable prescaler, and detects terminal count against a latched limit. It restarts the counter through a registered clear strobe and supports one-shot or periodic operation. It sits beside the counter instance, drives the counter's Enable and Clr, and reads back its Q.

Parameters:
WIDTH, 4, counter width; must match the controlled counter.
PRESCALE_W, 8, width of the prescale divider.

Ports:
Clk  input  1  system clock, rising edge.
Clr  input  1  asynchronous active-low reset.
start  input  1  pulse; begin a count sequence.
stop  input  1  pulse; abort the sequence and hold the counter value.
periodic  input  1  sampled at start; 1 = auto-restart at terminal count, 0 = one-shot.
limit  input  WIDTH  terminal count value, sampled at start.
prescale  input  PRESCALE_W  counter advances once every prescale+1 cycles; sampled at start.
cnt_q  input  WIDTH  Q of the controlled counter.
cnt_en  output  1  Enable to the counter (combinational: RUN & tick & cnt_q!=limit_r).
cnt_clr_n  output  1  registered active-low clear to the counter's Clr.
busy  output  1  high in CLEAR or RUN.
tc_pulse  output  1  one-cycle registered pulse at each terminal count.
done  output  1  high in DONE (one-shot finished).

Behaviour:
- Reset (Clr=0): state=IDLE, cnt_clr_n=0 (counter is held cleared while in reset), busy=0, tc_pulse=0, done=0, prescaler=0, limit_r=0, presc_r=0, periodic_r=0.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: cnt_clr_n=1. On start & !stop: latch limit, prescale and periodic; go to CLEAR.
- CLEAR: cnt_clr_n=0 for exactly one cycle; prescaler reset to 0; go to RUN.
- RUN: the prescaler counts 0..presc_r. tick=1 when prescaler==presc_r, and the prescaler then wraps to 0. presc_r=0 gives a tick every cycle.
  - On tick with cnt_q!=limit_r: cnt_en=1, and the counter increments on the same edge.
  - On tick with cnt_q==limit_r: cnt_en=0 and tc_pulse=1 next cycle. If periodic_r=1, go to CLEAR; otherwise go to DONE.
- DONE: done=1; the counter holds limit_r. Start goes to CLEAR with new latched values. Stop goes to IDLE.
- Stop in CLEAR or RUN: go to IDLE at the next edge; the counter holds its current value with no clear.
- Stop has priority over start in the same cycle in every state.
- Start while busy is ignored; the latched values are unchanged.
- limit=0 gives terminal count at the first tick after CLEAR, with zero increments.
- Period of the periodic sequence = 1 (CLEAR) + (limit+1)*(prescale+1) cycles.
- The counter never wraps past limit_r. limit=2^WIDTH-1 is legal.
- Asynchronous reset mid-sequence forces all reset values immediately; no pending tc_pulse is emitted.

Optional Feature:
Macro COUNTER_CTRL_PAUSE_EN.
- When defined: adds input pause (1 bit).
  - In RUN with pause=1, the prescaler freezes and cnt_en=0.
  - State, busy and latched values are held.
  - Stop still takes effect while paused.
- When not defined: no pause port; RUN always advances.

Decomposition:
- Shared package counter_ctrl_pkg holds:
  - the state encoding localparams ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_RUN=2'd2, ST_DONE=2'd3;
  - the default WIDTH and PRESCALE_W constants.
- One sub-module, tick_gen: prescaler register with load/clear and freeze inputs, emitting tick.
- The controller FSM, limit compare and output registers stay in counter_ctrl.
- The bench instantiates counter_ctrl together with the existing 4-bit T-FF counter.

Test Plan:
1. Reset, then start with limit=5, prescale=0, periodic=0 -> CLEAR 1 cycle; cnt_q steps 0..5 on consecutive cycles; tc_pulse once; done=1; cnt_q holds 5.
2. limit=3, prescale=2, periodic=1, run 40 cycles -> cnt_q advances every 3 cycles; tc_pulse every 13 cycles; busy stays 1.
3. limit=0, prescale=0, one-shot -> zero cnt_en pulses; tc_pulse 2 cycles after CLEAR exits; done=1 with cnt_q=0.
4. Stop asserted when cnt_q=2 (limit=7) -> IDLE next edge; cnt_q stays 2; busy=0; no tc_pulse. Start and stop together -> stays IDLE.
5. limit=15, prescale=0, periodic=1 -> cnt_q reaches 15 then CLEAR to 0; never wraps via increment; period 17 cycles.
6. Clr dropped low mid-RUN at cnt_q=4 -> outputs take reset values immediately and cnt_q=0. With COUNTER_CTRL_PAUSE_EN, pause for 5 cycles at cnt_q=3 -> cnt_q frozen, then resumes with the prescaler phase preserved.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter_ctrl sequencer.
// Holds the default counter/prescaler widths and the controller state encoding.
package counter_ctrl_pkg;

    localparam int unsigned WIDTH_DEF      = 4;
    localparam int unsigned PRESCALE_W_DEF = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_CLEAR = ST_CLEAR,
        S_RUN   = ST_RUN,
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/counter_ctrl_tick.sv
// tick_gen: prescale divider that pulses tick_c once every presc_r+1 cycles.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr         - force the divider back to phase 0
//   freeze      - hold the current phase
//   presc_r     - latched terminal phase
//   tick_c      - combinational, high while the divider sits at presc_r
module tick_gen
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  freeze,
    input  logic [PRESCALE_W-1:0] presc_r,
    output logic                  tick_c
);

    logic [PRESCALE_W-1:0] phase;

    assign tick_c = (phase == presc_r);

    // Phase counter wraps to 0 on the cycle after a tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clr) begin
            phase <= '0;
        end else if (!freeze) begin
            phase <= tick_c ? '0 : phase + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop sequencer for the T-FF ripple-enable counter.
// Clears the counter through a registered strobe, paces it with a prescaler
// and stops (one-shot) or restarts (periodic) when Q reaches the latched limit.
// Optional pause input enabled by defining COUNTER_CTRL_PAUSE_EN.
// Ports:
//   Clk, Clr              - clock, asynchronous active-low reset
//   start, stop           - command pulses (stop wins)
//   periodic/limit/prescale - sequence setup, latched on an accepted start
//   cnt_q                 - Q read back from the counter
//   pause                 - (COUNTER_CTRL_PAUSE_EN only) freeze RUN
//   cnt_en                - combinational enable to the counter
//   cnt_clr_n             - registered active-low clear to the counter
//   busy, tc_pulse, done  - registered status
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  Clk,
    input  logic                  Clr,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [WIDTH-1:0]      cnt_q,
`ifdef COUNTER_CTRL_PAUSE_EN
    input  logic                  pause,
`endif
    output logic                  cnt_en,
    output logic                  cnt_clr_n,
    output logic                  busy,
    output logic                  tc_pulse,
    output logic                  done
);

    state_t                state;
    state_t                state_nxt;
    logic [WIDTH-1:0]      limit_r;
    logic [PRESCALE_W-1:0] presc_r;
    logic                  periodic_r;

    logic tick_c;
    logic hold_c;
    logic run_tick_c;
    logic at_limit_c;
    logic load_c;

`ifdef COUNTER_CTRL_PAUSE_EN
    assign hold_c = pause;
`else
    assign hold_c = 1'b0;
`endif

    assign run_tick_c = (state == S_RUN) & tick_c & ~hold_c;
    assign at_limit_c = (cnt_q == limit_r);
    assign load_c     = start & ~stop & ((state == S_IDLE) | (state == S_DONE));

    // Stop also masks the enable so the counter holds the value seen with stop.
    assign cnt_en = run_tick_c & ~at_limit_c & ~stop;

    tick_gen #(.PRESCALE_W(PRESCALE_W)) u_tick (
        .clk     (Clk),
        .rst_n   (Clr),
        .clr     (state == S_CLEAR),
        .freeze  ((state != S_RUN) | hold_c),
        .presc_r (presc_r),
        .tick_c  (tick_c)
    );

    // Next-state decode; stop has priority over start everywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (load_c) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = stop ? S_IDLE : S_RUN;
            S_RUN: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (run_tick_c && at_limit_c) begin
                    state_nxt = periodic_r ? S_CLEAR : S_DONE;
                end
            end
            S_DONE: begin
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (start) begin
                    state_nxt = S_CLEAR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, latched setup and registered outputs (decoded from the next state).
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state      <= S_IDLE;
            cnt_clr_n  <= 1'b0;
            busy       <= 1'b0;
            tc_pulse   <= 1'b0;
            done       <= 1'b0;
            limit_r    <= '0;
            presc_r    <= '0;
            periodic_r <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_clr_n <= (state_nxt != S_CLEAR);
            busy      <= (state_nxt == S_CLEAR) | (state_nxt == S_RUN);
            done      <= (state_nxt == S_DONE);
            tc_pulse  <= run_tick_c & at_limit_c & ~stop;
            if (load_c) begin
                limit_r    <= limit;
                presc_r    <= prescale;
                periodic_r <= periodic;
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl driving a 4-bit T-FF ripple-enable counter.
// A timeline model predicts every output from the cycle offset since the
// accepted start; directed tests add literal expectations.
module tb_counter_ctrl;

    logic       Clk = 1'b0;
    logic       Clr = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] limit = 4'd0;
    logic [7:0] prescale = 8'd0;
    logic [3:0] cnt_q;
    logic       cnt_en, cnt_clr_n, busy, tc_pulse, done;
    logic       pse;
`ifdef COUNTER_CTRL_PAUSE_EN
    logic       pause = 1'b0;
    assign pse = pause;
`else
    assign pse = 1'b0;
`endif

    always #5 Clk = ~Clk;

    counter_ctrl #(.WIDTH(4), .PRESCALE_W(8)) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .limit     (limit),
        .prescale  (prescale),
        .cnt_q     (cnt_q),
`ifdef COUNTER_CTRL_PAUSE_EN
        .pause     (pause),
`endif
        .cnt_en    (cnt_en),
        .cnt_clr_n (cnt_clr_n),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done)
    );

    // The controlled 4-bit T-FF counter: bit i toggles when enabled and all lower bits are 1.
    logic [3:0] tog;
    always_comb begin
        tog[0] = cnt_en;
        for (int i = 1; i < 4; i++) tog[i] = tog[i-1] & cnt_q[i-1];
    end
    always_ff @(posedge Clk or negedge cnt_clr_n) begin
        if (!cnt_clr_n) cnt_q <= 4'd0;
        else            cnt_q <= cnt_q ^ tog;
    end

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle index, advanced on every rising edge.
    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Timeline model: m_s is the cycle index of the CLEAR cycle of the active sequence.
    bit          m_act = 0;
    bit          m_per = 0;
    int unsigned m_s = 0, m_l = 0, m_p = 0, m_hold = 0;
    int          e_region;  // 0 idle, 1 clear, 2 run, 3 done
    int          e_busy, e_done, e_tc, e_clrn, e_en, e_q;

    task automatic model_eval(input bit stp, input bit paused);
        int unsigned k, j, seg, runlen, per_len;
        e_region = 0; e_busy = 0; e_done = 0; e_tc = 0; e_clrn = 1; e_en = 0;
        e_q = int'(m_hold);
        if (m_act) begin
            seg     = m_p + 1;
            runlen  = (m_l + 1) * seg;
            per_len = 1 + runlen;
            k       = cyc - m_s;
            if (m_per) begin
                e_tc = int'(k > 0 && (k % per_len) == 0);
                k    = k % per_len;
            end
            if (k == 0) begin
                e_region = 1; e_busy = 1; e_clrn = 0; e_q = 0;
            end else begin
                j = k - 1;
                if (j >= runlen) begin
                    e_region = 3; e_done = 1; e_q = int'(m_l);
                    e_tc = int'(j == runlen);
                end else begin
                    e_region = 2; e_busy = 1; e_q = int'(j / seg);
                    e_en = int'((j % seg) == m_p && e_q != int'(m_l) && !stp && !paused);
                end
            end
        end
    endtask

    bit          settle = 1;
    int          tc_seen = 0, en_seen = 0;
    int unsigned last_tc = 0, tc_period = 0;

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs.
    always @(negedge Clk) begin
        if (!Clr) begin
            m_act = 0; m_hold = 0; settle = 1;
        end else if (settle) begin
            settle = 0;
        end else begin
            model_eval(stop, pse);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("tc_pulse", tc_pulse, e_tc);
            chk("cnt_clr_n", cnt_clr_n, e_clrn);
            chk("cnt_en", cnt_en, e_en);
            chk("cnt_q", cnt_q, e_q);
            if (tc_pulse) begin
                tc_seen++;
                tc_period = cyc - last_tc;
                last_tc   = cyc;
            end
            if (cnt_en) en_seen++;
            if (stop) begin
                if (m_act) begin m_act = 0; m_hold = e_q; end
            end else if (start && (e_region == 0 || e_region == 3)) begin
                m_act = 1; m_s = cyc + 1; m_l = limit; m_p = prescale; m_per = periodic;
            end else if (pse && e_region == 2) begin
                m_s++;
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic go(input int l, input int p, input bit per);
        limit = 4'(l); prescale = 8'(p); periodic = per;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic wait_q(input int v, input int maxc);
        for (int i = 0; i < maxc && int'(cnt_q) != v; i++) step();
        chk("wait_q", cnt_q, v);
    endtask

    int t0;

    initial begin
        // Reset values
        step(); step();
        chk("rst_clr_n", cnt_clr_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt_q", cnt_q, 0);
        Clr = 1'b1;
        step(); step();

        // One-shot, limit 5, prescale 0
        t0 = tc_seen;
        go(5, 0, 0);
        chk("t1_clear", cnt_clr_n, 0);
        chk("t1_busy", busy, 1);
        repeat (8) step();
        chk("t1_done", done, 1);
        chk("t1_q", cnt_q, 5);
        chk("t1_tc_count", tc_seen - t0, 1);
        halt();

        // Periodic, limit 3, prescale 2; a start mid-run must be ignored
        t0 = tc_seen;
        go(3, 2, 1);
        repeat (20) step();
        limit = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        repeat (19) step();
        chk("t2_tc_count", tc_seen - t0, 3);
        chk("t2_busy", busy, 1);
        halt();

        // limit 0: no increments, terminal count at the first tick
        t0 = en_seen;
        go(0, 0, 0);
        step(); step();
        chk("t3_tc", tc_pulse, 1);
        chk("t3_done", done, 1);
        chk("t3_q", cnt_q, 0);
        step();
        chk("t3_en_count", en_seen - t0, 0);
        halt();

        // Stop at cnt_q=2 holds the value; start+stop together stays idle
        t0 = tc_seen;
        go(7, 0, 0);
        wait_q(2, 20);
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        chk("t4_q_hold", cnt_q, 2);
        chk("t4_busy", busy, 0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        chk("t4_both_busy", busy, 0);
        chk("t4_both_q", cnt_q, 2);
        chk("t4_no_tc", tc_seen - t0, 0);

        // Full range periodic: period 17
        go(15, 0, 1);
        repeat (40) step();
        chk("t5_period", tc_period, 17);
        halt();

`ifdef COUNTER_CTRL_PAUSE_EN
        // Pause at cnt_q=3 for 5 cycles, mid prescale phase
        go(7, 2, 0);
        wait_q(3, 40);
        step();
        pause = 1'b1;
        repeat (5) step();
        chk("t6p_frozen", cnt_q, 3);
        pause = 1'b0;
        step();
        chk("t6p_phase", cnt_q, 3);
        step();
        chk("t6p_resume", cnt_q, 4);
        halt();
`endif

        // Async reset on the terminal-count cycle: no pending tc_pulse
        go(4, 0, 0);
        wait_q(4, 20);
        #2 Clr = 1'b0;
        #1;
        chk("t6_q", cnt_q, 0);
        chk("t6_busy", busy, 0);
        chk("t6_clr_n", cnt_clr_n, 0);
        chk("t6_tc", tc_pulse, 0);
        chk("t6_en", cnt_en, 0);
        step(); step();
        Clr = 1'b1;
        step(); step();
        chk("t6_after_tc", tc_pulse, 0);
        chk("t6_after_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
